// File: rtl/exe_muldiv_if.sv
// rtl/exe_muldiv_if.sv - EXE-stage multiply/divide handshake bundle
//
// Groups the pipeline-side operands/controls and the unit's results.
//   master : pipeline side (drives opcode, operands, flush; reads stall/done/HI/LO)
//   slave  : exe_muldiv unit
// Optional MULDIV_MADD_EN adds EXE_HIin/EXE_LOin (forwarded architectural HI/LO).
interface exe_muldiv_if;
  logic [2:0]  EXE_MulDivOp;
  logic [31:0] EXE_BusA;
  logic [31:0] EXE_BusB;
  logic        MEM_Flush;
  logic        EXE_MulDivStall;
  logic        EXE_MulDivDone;
  logic [31:0] EXE_HI;
  logic [31:0] EXE_LO;
`ifdef MULDIV_MADD_EN
  logic [31:0] EXE_HIin;
  logic [31:0] EXE_LOin;

  modport master (
    output EXE_MulDivOp, EXE_BusA, EXE_BusB, MEM_Flush, EXE_HIin, EXE_LOin,
    input  EXE_MulDivStall, EXE_MulDivDone, EXE_HI, EXE_LO
  );

  modport slave (
    input  EXE_MulDivOp, EXE_BusA, EXE_BusB, MEM_Flush, EXE_HIin, EXE_LOin,
    output EXE_MulDivStall, EXE_MulDivDone, EXE_HI, EXE_LO
  );
`else
  modport master (
    output EXE_MulDivOp, EXE_BusA, EXE_BusB, MEM_Flush,
    input  EXE_MulDivStall, EXE_MulDivDone, EXE_HI, EXE_LO
  );

  modport slave (
    input  EXE_MulDivOp, EXE_BusA, EXE_BusB, MEM_Flush,
    output EXE_MulDivStall, EXE_MulDivDone, EXE_HI, EXE_LO
  );
`endif
endinterface

// File: rtl/exe_muldiv.sv
// rtl/exe_muldiv.sv - multi-cycle multiply/divide unit for the EXE stage
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   md   : exe_muldiv_if.slave
//          EXE_MulDivOp (0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MSUB)
//          EXE_BusA/EXE_BusB operands, MEM_Flush cancel,
//          EXE_MulDivStall hold-front, EXE_MulDivDone one-cycle result pulse,
//          EXE_HI/EXE_LO result (product high/low or remainder/quotient)
// Parameter MUL_LAT (1..4): cycles spent in MUL before DONE.
// Macro MULDIV_MADD_EN: enables MADD/MSUB (ops 5/6) with EXE_HIin/EXE_LOin,
// one extra accumulate cycle. Undefined: ops 5..7 are no-ops.
module exe_muldiv #(
  parameter int MUL_LAT = 2
) (
  input logic         clk,
  input logic         rst,
  exe_muldiv_if.slave md
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
`endif

  // Product pipeline depth ahead of the HI/LO register; at least one entry
  // is declared so MUL_LAT=1 still elaborates (it then bypasses the array).
  localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] dvs_q, quo_q, rem_q;
  logic        neg_quo_q, neg_rem_q;
  logic [63:0] pipe_q [PD];
  logic [31:0] hi_q, lo_q, hi_prev, lo_prev;
`ifdef MULDIV_MADD_EN
  logic [63:0] hilo_in_q;
  logic [63:0] acc_q;
`endif

  // ---------------------------------------------------------------- decode
  logic op_mul, op_acc, op_div, start;
  logic a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    op_mul = (md.EXE_MulDivOp == OP_MULT) || (md.EXE_MulDivOp == OP_MULTU);
    op_acc = 1'b0;
`ifdef MULDIV_MADD_EN
    op_acc = (md.EXE_MulDivOp == OP_MADD) || (md.EXE_MulDivOp == OP_MSUB);
`endif
    op_div = (md.EXE_MulDivOp == OP_DIV) || (md.EXE_MulDivOp == OP_DIVU);
    start  = (op_mul || op_acc || op_div) && !md.MEM_Flush;

    // Divide runs on magnitudes; signs are applied to the final result.
    a_neg = (md.EXE_MulDivOp == OP_DIV) && md.EXE_BusA[31];
    b_neg = (md.EXE_MulDivOp == OP_DIV) && md.EXE_BusB[31];
    a_mag = a_neg ? -md.EXE_BusA : md.EXE_BusA;
    b_mag = b_neg ? -md.EXE_BusB : md.EXE_BusB;
  end

  // -------------------------------------------------------------- multiply
  // Operands are sign- or zero-extended to 64 bits; the low 64 bits of the
  // product are then correct for both signed and unsigned forms.
  logic        mul_signed;
  logic [63:0] ma, mb, prod, mul_tail, mul_fin;

  always_comb begin
    mul_signed = (op_q != OP_MULTU);
    ma         = {{32{mul_signed & a_q[31]}}, a_q};
    mb         = {{32{mul_signed & b_q[31]}}, b_q};
    prod       = ma * mb;
    mul_tail   = (MUL_LAT > 1) ? pipe_q[PD-1] : prod;
    mul_fin    = mul_tail;
`ifdef MULDIV_MADD_EN
    if ((op_q == OP_MADD) || (op_q == OP_MSUB)) begin
      mul_fin = acc_q;
    end
`endif
  end

  // ---------------------------------------------------------------- divide
  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits.
  logic [32:0] rem_sh;
  logic        q_bit;
  logic [31:0] rem_nxt, quo_nxt, div_hi, div_lo;

  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    q_bit   = (rem_sh >= {1'b0, dvs_q});
    rem_nxt = q_bit ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
    quo_nxt = {quo_q[30:0], q_bit};
    div_lo  = neg_quo_q ? -quo_nxt : quo_nxt;
    div_hi  = neg_rem_q ? -rem_nxt : rem_nxt;
  end

  // ------------------------------------------------------------------- FSM
  logic stall, done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = op_div ? S_DIV : S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        stall = 1'b1;
        if (md.MEM_Flush) begin
          state_nxt = S_IDLE;
        end else if (cnt == 5'd0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = !md.MEM_Flush;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Start decode is combinational, so gate it out while reset is held.
    if (!rst) begin
      stall = 1'b0;
    end
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 5'd0;
      op_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      dvs_q     <= 32'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_prev   <= 32'd0;
      lo_prev   <= 32'd0;
      for (int i = 0; i < PD; i++) begin
        pipe_q[i] <= 64'd0;
      end
`ifdef MULDIV_MADD_EN
      hilo_in_q <= 64'd0;
      acc_q     <= 64'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q      <= md.EXE_MulDivOp;
            a_q       <= md.EXE_BusA;
            b_q       <= md.EXE_BusB;
            dvs_q     <= b_mag;
            quo_q     <= a_mag;
            rem_q     <= 32'd0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (op_div) begin
              cnt <= 5'd31;
            end else if (op_acc) begin
              cnt <= 5'(MUL_LAT);
            end else begin
              cnt <= 5'(MUL_LAT - 1);
            end
`ifdef MULDIV_MADD_EN
            hilo_in_q <= {md.EXE_HIin, md.EXE_LOin};
`endif
          end
        end
        S_MUL: begin
          if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
          end
          // Operands are stable for the whole MUL stay, so the pipe simply
          // fills and then holds the same product.
          pipe_q[0] <= prod;
          for (int i = 1; i < PD; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
`ifdef MULDIV_MADD_EN
          acc_q <= (op_q == OP_MSUB) ? (hilo_in_q - mul_tail) : (hilo_in_q + mul_tail);
`endif
          if (!md.MEM_Flush && (cnt == 5'd0)) begin
            hi_prev <= hi_q;
            lo_prev <= lo_q;
            hi_q    <= mul_fin[63:32];
            lo_q    <= mul_fin[31:0];
          end
        end
        S_DIV: begin
          if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
          end
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (!md.MEM_Flush && (cnt == 5'd0)) begin
            hi_prev <= hi_q;
            lo_prev <= lo_q;
            hi_q    <= div_hi;
            lo_q    <= div_lo;
          end
        end
        S_DONE: begin
          // A flush that lands on the result cycle kills the instruction,
          // so the architectural-looking outputs revert.
          if (md.MEM_Flush) begin
            hi_q <= hi_prev;
            lo_q <= lo_prev;
          end
        end
        default: ;
      endcase
    end
  end

  assign md.EXE_MulDivStall = stall;
  assign md.EXE_MulDivDone  = done;
  assign md.EXE_HI          = hi_q;
  assign md.EXE_LO          = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb/tb_exe_muldiv.sv - self-checking bench for exe_muldiv
module tb_exe_muldiv;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exe_muldiv_if bus_if ();

  exe_muldiv #(.MUL_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus_if)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference
  function automatic bit op_valid(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return (op >= 3'd1) && (op <= 3'd6);
`else
    return (op >= 3'd1) && (op <= 3'd4);
`endif
  endfunction

  function automatic int op_lat(input logic [2:0] op);
    if (op == 3'd3 || op == 3'd4) return 33;
    if (op == 3'd5 || op == 3'd6) return LAT + 2;
    return LAT + 1;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] hilo_in);
    longint      sp;
    logic [31:0] q, r;
    case (op)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) begin
          q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
          r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = 32'd0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
        return {r, q};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd5: return hilo_in + 64'(longint'($signed(a)) * longint'($signed(b)));
      3'd6: return hilo_in - 64'(longint'($signed(a)) * longint'($signed(b)));
      default: return 64'd0;
    endcase
  endfunction

  // --------------------------------------------------- per-cycle compare
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_done = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_res;
  logic        e_stall, e_done, in_done;
  logic [63:0] hilo_in;

  always @(negedge clk) begin
    cyc++;
`ifdef MULDIV_MADD_EN
    hilo_in = {bus_if.EXE_HIin, bus_if.EXE_LOin};
`else
    hilo_in = 64'd0;
`endif
    in_done = 1'b0;
    e_done  = 1'b0;
    if (!rst) begin
      e_stall = 1'b0;
      m_busy  = 1'b0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;
    end else if (!m_busy) begin
      e_stall = op_valid(bus_if.EXE_MulDivOp) && !bus_if.MEM_Flush;
      if (e_stall) begin
        m_busy = 1'b1;
        m_done = cyc + op_lat(bus_if.EXE_MulDivOp);
        m_res  = model(bus_if.EXE_MulDivOp, bus_if.EXE_BusA, bus_if.EXE_BusB, hilo_in);
      end
    end else if (cyc < m_done) begin
      e_stall = 1'b1;
      if (bus_if.MEM_Flush) m_busy = 1'b0;
    end else begin
      in_done = 1'b1;
      e_stall = 1'b0;
      e_done  = !bus_if.MEM_Flush;
      m_busy  = 1'b0;
    end
    check("cmp_stall", {31'd0, bus_if.EXE_MulDivStall}, {31'd0, e_stall});
    check("cmp_done", {31'd0, bus_if.EXE_MulDivDone}, {31'd0, e_done});
    if (in_done) begin
      check("cmp_hi_done", bus_if.EXE_HI, m_res[63:32]);
      check("cmp_lo_done", bus_if.EXE_LO, m_res[31:0]);
      if (!bus_if.MEM_Flush) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
      end
    end else begin
      check("cmp_hi_hold", bus_if.EXE_HI, m_hi);
      check("cmp_lo_hold", bus_if.EXE_LO, m_lo);
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int elat);
    int lat = -1;
    int st  = 0;
    @(posedge clk); #1;
    bus_if.EXE_MulDivOp = op;
    bus_if.EXE_BusA     = a;
    bus_if.EXE_BusB     = b;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus_if.EXE_MulDivStall) st++;
      if (bus_if.EXE_MulDivDone) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: no done pulse within 60 cycles", tag);
    end
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_stalls"}, 32'(st), 32'(elat));
    check({tag, "_hi"}, bus_if.EXE_HI, ehi);
    check({tag, "_lo"}, bus_if.EXE_LO, elo);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bus_if.EXE_MulDivOp = 3'd0;
  endtask

  int dcount;

  initial begin
    bus_if.EXE_MulDivOp = 3'd0;
    bus_if.EXE_BusA     = 32'd0;
    bus_if.EXE_BusB     = 32'd0;
    bus_if.MEM_Flush    = 1'b0;
`ifdef MULDIV_MADD_EN
    bus_if.EXE_HIin     = 32'd0;
    bus_if.EXE_LOin     = 32'd0;
`endif
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'd0, bus_if.EXE_MulDivStall}, 32'd0);
    check("reset_hi", bus_if.EXE_HI, 32'd0);
    check("reset_lo", bus_if.EXE_LO, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Back-to-back: each do_op starts in the cycle after the previous DONE.
    do_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT + 1);
    do_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT + 1);
    do_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    do_op("divu_big", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 33);
    do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    do_op("divu_zero", 3'd4, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 33);
    do_op("div_negzero", 3'd3, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0001, 33);
    go_idle();

    // Flush a DIVU in its 10th cycle: no result, outputs unchanged.
    @(posedge clk); #1;
    bus_if.EXE_MulDivOp = 3'd4;
    bus_if.EXE_BusA     = 32'd1000;
    bus_if.EXE_BusB     = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus_if.MEM_Flush    = 1'b1;
    bus_if.EXE_MulDivOp = 3'd0;
    @(posedge clk); #1;
    bus_if.MEM_Flush    = 1'b0;
    @(negedge clk);
    check("flush_div_stall", {31'd0, bus_if.EXE_MulDivStall}, 32'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_if.EXE_MulDivDone) dcount++;
    end
    check("flush_div_nodone", 32'(dcount), 32'd0);
    check("flush_div_hi", bus_if.EXE_HI, 32'hFFFF_FFFB);
    check("flush_div_lo", bus_if.EXE_LO, 32'h0000_0001);

    do_op("multu_small", 3'd2, 32'd3, 32'd4, 32'd0, 32'd12, LAT + 1);
    go_idle();

    // Flush landing on the DONE cycle suppresses the pulse and restores HI/LO.
    @(posedge clk); #1;
    bus_if.EXE_MulDivOp = 3'd2;
    bus_if.EXE_BusA     = 32'd7;
    bus_if.EXE_BusB     = 32'd6;
    repeat (LAT + 1) @(posedge clk);
    #1;
    bus_if.MEM_Flush    = 1'b1;
    bus_if.EXE_MulDivOp = 3'd0;
    @(negedge clk);
    check("flush_done_pulse", {31'd0, bus_if.EXE_MulDivDone}, 32'd0);
    @(posedge clk); #1;
    bus_if.MEM_Flush = 1'b0;
    @(negedge clk);
    check("flush_done_hi", bus_if.EXE_HI, 32'd0);
    check("flush_done_lo", bus_if.EXE_LO, 32'd12);

    // Non-starting opcodes and a flush-blocked start.
    @(posedge clk); #1 bus_if.EXE_MulDivOp = 3'd7;
    @(negedge clk);
    check("op7_nostall", {31'd0, bus_if.EXE_MulDivStall}, 32'd0);
`ifndef MULDIV_MADD_EN
    @(posedge clk); #1 bus_if.EXE_MulDivOp = 3'd5;
    @(negedge clk);
    check("op5_nostall", {31'd0, bus_if.EXE_MulDivStall}, 32'd0);
`endif
    @(posedge clk); #1;
    bus_if.EXE_MulDivOp = 3'd1;
    bus_if.MEM_Flush    = 1'b1;
    @(negedge clk);
    check("idle_flush_nostall", {31'd0, bus_if.EXE_MulDivStall}, 32'd0);
    @(posedge clk); #1;
    bus_if.EXE_MulDivOp = 3'd0;
    bus_if.MEM_Flush    = 1'b0;

    // Asynchronous reset in the middle of a DIV.
    @(posedge clk); #1;
    bus_if.EXE_MulDivOp = 3'd3;
    bus_if.EXE_BusA     = 32'd77;
    bus_if.EXE_BusB     = 32'd5;
    repeat (15) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, bus_if.EXE_MulDivStall}, 32'd0);
    check("rst_mid_hi", bus_if.EXE_HI, 32'd0);
    check("rst_mid_lo", bus_if.EXE_LO, 32'd0);
    @(posedge clk); #1 bus_if.EXE_MulDivOp = 3'd0;
    @(posedge clk); #1 rst = 1'b1;

    do_op("divu_after_rst", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    go_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
